// File: rtl/aes_mcol_sched_pkg.sv
// Shared constants and types for the column-serial MixColumns engine.
// AES_MCOL_INV_EN (defined elsewhere) adds the InvMixColumns option; nothing here depends on it.
package aes_mcol_sched_pkg;

  localparam int Nb   = 4;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mcol_sched_state_t;

  // One column is four row bytes; a full state packs byte 4*c+r at index 4*c+r.
  typedef logic [3:0][7:0]      mcol_col_t;
  typedef logic [4*Nb-1:0][7:0] mcol_state_t;

endpackage

// File: rtl/aes_mcol_sched_if.sv
// Requester, consumer and status signals of the MixColumns engine.
// With AES_MCOL_INV_EN defined, each request carries an inverse-select bit echoed on out_inv.
interface aes_mcol_sched_if;
  import aes_mcol_sched_pkg::*;

  logic        req0_valid;
  logic        req0_ready;
  mcol_state_t req0_state;
  logic        req1_valid;
  logic        req1_ready;
  mcol_state_t req1_state;
  logic        out_valid;
  logic        out_ready;
  mcol_state_t out_state;
  logic        out_id;
  logic        busy;
`ifdef AES_MCOL_INV_EN
  logic        req0_inv;
  logic        req1_inv;
  logic        out_inv;
`endif

  modport master (
    output req0_valid, req0_state, req1_valid, req1_state, out_ready,
`ifdef AES_MCOL_INV_EN
    output req0_inv, req1_inv,
    input  out_inv,
`endif
    input  req0_ready, req1_ready, out_valid, out_state, out_id, busy
  );

  modport slave (
    input  req0_valid, req0_state, req1_valid, req1_state, out_ready,
`ifdef AES_MCOL_INV_EN
    input  req0_inv, req1_inv,
    output out_inv,
`endif
    output req0_ready, req1_ready, out_valid, out_state, out_id, busy
  );

endinterface

// File: rtl/aes_mcol_sched_col.sv
// Combinational MixColumns on a single column in GF(2^8) mod 0x11B.
// AES_MCOL_INV_EN adds inv_i selecting the InvMixColumns coefficients.
module aes_mcol_col
  import aes_mcol_sched_pkg::*;
(
  input  mcol_col_t col_i,
`ifdef AES_MCOL_INV_EN
  input  logic      inv_i,
`endif
  output mcol_col_t col_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  mcol_col_t x2;
  mcol_col_t fwdCol;

  // Forward row r: 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3], with 03*a = 02*a ^ a.
  always_comb begin
    x2     = '0;
    fwdCol = '0;
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(col_i[r]);
    end
    for (int r = 0; r < 4; r++) begin
      fwdCol[r] = x2[r] ^ x2[(r+1)%4] ^ col_i[(r+1)%4] ^ col_i[(r+2)%4] ^ col_i[(r+3)%4];
    end
  end

`ifdef AES_MCOL_INV_EN
  mcol_col_t x4;
  mcol_col_t x8;
  mcol_col_t invCol;

  // Inverse coefficients built from powers of two: 0e=8^4^2, 0b=8^2^1, 0d=8^4^1, 09=8^1.
  always_comb begin
    x4     = '0;
    x8     = '0;
    invCol = '0;
    for (int r = 0; r < 4; r++) begin
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      invCol[r] = (x8[r] ^ x4[r] ^ x2[r])
                ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ col_i[(r+1)%4])
                ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ col_i[(r+2)%4])
                ^ (x8[(r+3)%4] ^ col_i[(r+3)%4]);
    end
  end

  assign col_o = inv_i ? invCol : fwdCol;
`else
  assign col_o = fwdCol;
`endif

endmodule

// File: rtl/aes_mcol_sched.sv
// Column-serial MixColumns engine shared by two requesters through a round-robin arbiter.
// Define AES_MCOL_INV_EN to add per-request InvMixColumns selection (req*_inv, out_inv).
module aes_mcol_sched
  import aes_mcol_sched_pkg::*;
(
  input logic             clock,
  input logic             reset,
  aes_mcol_sched_if.slave bus
);

  localparam int ColW = $clog2(Nb);

  mcol_sched_state_t state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  mcol_state_t       buf_q, buf_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic              grant0, grant1;
  mcol_col_t         colIn, colOut;
`ifdef AES_MCOL_INV_EN
  logic              inv_q, inv_d;
`endif

  // ptr_q remembers the last winner, so on a tie the other requester is favoured.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ptr_q);
  assign grant1 = bus.req1_valid & ~grant0;

  always_comb begin
    colIn = '0;
    for (int r = 0; r < 4; r++) begin
      colIn[r] = buf_q[{col_q, 2'(r)}];
    end
  end

  aes_mcol_col u_col (
    .col_i (colIn),
`ifdef AES_MCOL_INV_EN
    .inv_i (inv_q),
`endif
    .col_o (colOut)
  );

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    buf_d          = buf_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
`ifdef AES_MCOL_INV_EN
    inv_d          = inv_q;
`endif
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 | grant1) begin
          buf_d   = grant0 ? bus.req0_state : bus.req1_state;
          owner_d = grant1;
          ptr_d   = grant1;
          col_d   = '0;
          state_d = RUN;
`ifdef AES_MCOL_INV_EN
          inv_d   = grant0 ? bus.req0_inv : bus.req1_inv;
`endif
        end
      end
      RUN: begin
        for (int r = 0; r < 4; r++) begin
          buf_d[{col_q, 2'(r)}] = colOut[r];
        end
        col_d = col_q + ColW'(1);
        if (col_q == ColW'(Nb-1)) begin
          col_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      buf_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
`ifdef AES_MCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef AES_MCOL_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = buf_q;
  assign bus.out_id    = owner_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef AES_MCOL_INV_EN
  assign bus.out_inv   = inv_q;
`endif

endmodule

// File: tb/tb_aes_mcol_sched.sv
// Randomized bench for aes_mcol_sched against a GF(2^8) matrix-multiply reference model.
// Exercises the inverse path too when AES_MCOL_INV_EN is defined.
module tb_aes_mcol_sched;
  import aes_mcol_sched_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clock = ~clock;

  aes_mcol_sched_if bus();

  aes_mcol_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B afterwards.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic mcol_state_t refMix(input mcol_state_t s, input bit inv);
    logic [7:0]  k[4];
    mcol_state_t o;
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < Nb; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[4*c+r] = o[4*c+r] ^ gmul(k[j], s[4*c + (r+j)%4]);
    return o;
  endfunction

  function automatic mcol_state_t colsToState(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] c[4];
    mcol_state_t s;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 4; r++)
        s[4*i+r] = c[i][31-8*r -: 8];
    return s;
  endfunction

  function automatic mcol_state_t randState();
    mcol_state_t s;
    for (int i = 0; i < 4*Nb; i++) s[i] = 8'($urandom);
    return s;
  endfunction

  task automatic applyStimulus();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_state = '0;
    bus.req1_state = '0;
    bus.out_ready  = 1'b0;
`ifdef AES_MCOL_INV_EN
    bus.req0_inv   = 1'b0;
    bus.req1_inv   = 1'b0;
`endif
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Drives one request, waits for its accept and result; ok=0 when a bounded wait expires.
  task automatic runOne(input bit which, input mcol_state_t st, input bit inv,
                        output mcol_state_t got, output bit gotId, output bit gotInv,
                        output int lat, output bit ok);
    int n;
    ok = 1'b1; got = '0; gotId = 1'b0; gotInv = 1'b0; lat = 0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    if (which) begin bus.req1_valid = 1'b1; bus.req1_state = st; end
    else       begin bus.req0_valid = 1'b1; bus.req0_state = st; end
`ifdef AES_MCOL_INV_EN
    bus.req0_inv = inv;
    bus.req1_inv = inv;
`else
    if (inv) ok = 1'b0;
`endif
    #1;
    n = 0;
    while (!(which ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) begin
      ok = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    @(negedge clock);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 1;
    #1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clock); #1; lat++;
    end
    if (!bus.out_valid) ok = 1'b0;
    got   = bus.out_state;
    gotId = bus.out_id;
`ifdef AES_MCOL_INV_EN
    gotInv = bus.out_inv;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus();
    #2 reset = 1'b0;
    @(negedge clock); #1;
    testsRun++;
    if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    testsRun++;
    if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    testsRun++;
    if (bus.out_id !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_id got=%b exp=0", bus.out_id); end
    testsRun++;
    if (bus.out_state !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_state got=%h exp=0", bus.out_state); end
    testsRun++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL reset_readies got=%b exp=00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_forward();
    mcol_state_t st, got, exp;
    bit id, iv, ok;
    int lat;
    doReset();
    st  = colsToState(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    exp = colsToState(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    runOne(1'b0, st, 1'b0, got, id, iv, lat, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL fwd_timeout got=timeout exp=result"); end
    testsRun++;
    if (lat != 5) begin testsFailed++; $display("[TB] FAIL fwd_latency got=%0d exp=5", lat); end
    testsRun++;
    if (got !== exp) begin testsFailed++; $display("[TB] FAIL fwd_state got=%h exp=%h", got, exp); end
    testsRun++;
    if (id !== 1'b0) begin testsFailed++; $display("[TB] FAIL fwd_id got=%b exp=0", id); end
  endtask

  task automatic test_tie_round_robin();
    mcol_state_t s0, s1, e;
    int accIds[$], accCyc[$], outIds[$];
    mcol_state_t outSt[$];
    bit both;
    doReset();
    both = 1'b0;
    s0 = randState();
    s1 = randState();
    @(negedge clock);
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_state = s0;
    bus.req1_valid = 1'b1; bus.req1_state = s1;
    for (int cyc = 0; cyc < 60 && outIds.size() < 3; cyc++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both = 1'b1;
      if (bus.req0_ready) begin accIds.push_back(0); accCyc.push_back(cyc); end
      if (bus.req1_ready) begin accIds.push_back(1); accCyc.push_back(cyc); end
      if (bus.out_valid) begin outIds.push_back(int'(bus.out_id)); outSt.push_back(bus.out_state); end
      if (outIds.size() < 3) @(negedge clock);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    testsRun++;
    if (both) begin testsFailed++; $display("[TB] FAIL tie_dual_grant got=1 exp=0"); end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (i >= accIds.size() || accIds[i] != i % 2) begin
        testsFailed++;
        $display("[TB] FAIL tie_grant%0d got=%0d exp=%0d", i, (i < accIds.size()) ? accIds[i] : -1, i % 2);
      end
      testsRun++;
      if (i >= outIds.size() || outIds[i] != i % 2) begin
        testsFailed++;
        $display("[TB] FAIL tie_out_id%0d got=%0d exp=%0d", i, (i < outIds.size()) ? outIds[i] : -1, i % 2);
      end
      e = refMix((i % 2) ? s1 : s0, 1'b0);
      testsRun++;
      if (i >= outSt.size() || outSt[i] !== e) begin
        testsFailed++;
        $display("[TB] FAIL tie_state%0d got=%h exp=%h", i, (i < outSt.size()) ? outSt[i] : '0, e);
      end
    end
    for (int i = 1; i < 3; i++) begin
      testsRun++;
      if (i >= accCyc.size() || accCyc[i] - accCyc[i-1] != 6) begin
        testsFailed++;
        $display("[TB] FAIL tie_spacing%0d got=%0d exp=6", i, (i < accCyc.size()) ? accCyc[i] - accCyc[i-1] : -1);
      end
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_backpressure();
    mcol_state_t s, holdSt, e;
    bit holdId;
    int n, stableBad, readyBad;
    doReset();
    s = randState();
    @(negedge clock);
    bus.out_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_state = s;
    #1; n = 0;
    while (!bus.req0_ready && n < 20) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_state = randState();
    #1; n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clock); #1; n++; end
    testsRun++;
    if (!bus.out_valid) begin testsFailed++; $display("[TB] FAIL bp_timeout got=timeout exp=out_valid"); end
    holdSt = bus.out_state;
    holdId = bus.out_id;
    e = refMix(s, 1'b0);
    testsRun++;
    if (holdSt !== e) begin testsFailed++; $display("[TB] FAIL bp_state got=%h exp=%h", holdSt, e); end
    testsRun++;
    if (holdId !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_id got=%b exp=0", holdId); end
    stableBad = 0; readyBad = 0;
    repeat (10) begin
      @(negedge clock); #1;
      if (!bus.out_valid || bus.out_state !== holdSt || bus.out_id !== holdId) stableBad++;
      if (bus.req0_ready || bus.req1_ready) readyBad++;
    end
    testsRun++;
    if (stableBad != 0) begin testsFailed++; $display("[TB] FAIL bp_stable got=%0d exp=0", stableBad); end
    testsRun++;
    if (readyBad != 0) begin testsFailed++; $display("[TB] FAIL bp_ready_held got=%0d exp=0", readyBad); end
    bus.out_ready = 1'b1;
    #1;
    testsRun++;
    if (bus.req1_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_same_cycle_accept got=%b exp=0", bus.req1_ready); end
    @(negedge clock); #1;
    testsRun++;
    if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_release got=%b exp=0", bus.out_valid); end
    testsRun++;
    if (bus.req1_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_next_accept got=%b exp=1", bus.req1_ready); end
    @(negedge clock);
    bus.req1_valid = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    mcol_state_t s, got, e;
    bit id, iv, ok;
    int n, lat, bad;
    doReset();
    @(negedge clock);
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_state = randState();
    #1; n = 0;
    while (!bus.req0_ready && n < 20) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    testsRun++;
    if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrun_busy got=%b exp=1", bus.busy); end
    reset = 1'b0;
    #1;
    testsRun++;
    if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrun_out_valid got=%b exp=0", bus.out_valid); end
    testsRun++;
    if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrun_busy_cleared got=%b exp=0", bus.busy); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (8) begin @(negedge clock); #1; if (bus.out_valid || bus.busy) bad++; end
    testsRun++;
    if (bad != 0) begin testsFailed++; $display("[TB] FAIL midrun_no_output got=%0d exp=0", bad); end
    s = colsToState(32'hd4d4d4d5, $urandom, $urandom, $urandom);
    e = refMix(s, 1'b0);
    runOne(1'b1, s, 1'b0, got, id, iv, lat, ok);
    testsRun++;
    if (!ok || lat != 5) begin testsFailed++; $display("[TB] FAIL midrun_fresh_latency got=%0d exp=5", lat); end
    testsRun++;
    if ({got[0], got[1], got[2], got[3]} !== 32'hd5d5d7d6) begin
      testsFailed++; $display("[TB] FAIL midrun_col0 got=%h exp=d5d5d7d6", {got[0], got[1], got[2], got[3]});
    end
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL midrun_state got=%h exp=%h", got, e); end
    testsRun++;
    if (id !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrun_id got=%b exp=1", id); end
  endtask

`ifdef AES_MCOL_INV_EN
  task automatic test_inverse();
    mcol_state_t s, got, e;
    bit id, iv, ok;
    int lat;
    doReset();
    s = colsToState(32'h8e4da1bc, $urandom, $urandom, $urandom);
    e = refMix(s, 1'b1);
    runOne(1'b1, s, 1'b1, got, id, iv, lat, ok);
    testsRun++;
    if (!ok || lat != 5) begin testsFailed++; $display("[TB] FAIL inv_latency got=%0d exp=5", lat); end
    testsRun++;
    if ({got[0], got[1], got[2], got[3]} !== 32'hdb135345) begin
      testsFailed++; $display("[TB] FAIL inv_col0 got=%h exp=db135345", {got[0], got[1], got[2], got[3]});
    end
    testsRun++;
    if (got !== e) begin testsFailed++; $display("[TB] FAIL inv_state got=%h exp=%h", got, e); end
    testsRun++;
    if (iv !== 1'b1) begin testsFailed++; $display("[TB] FAIL inv_out_inv got=%b exp=1", iv); end
  endtask
`endif

  task automatic test_idle_hold();
    doReset();
    repeat (20) begin
      @(negedge clock); #1;
      testsRun++;
      if ({bus.busy, bus.out_valid, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
        testsFailed++;
        $display("[TB] FAIL idle_hold got=%b exp=0000", {bus.busy, bus.out_valid, bus.req0_ready, bus.req1_ready});
      end
    end
  endtask

  task automatic test_random();
    mcol_state_t s, got, e;
    bit which, inv, id, iv, ok;
    int lat;
    doReset();
    for (int t = 0; t < 10; t++) begin
      which = 1'($urandom);
      s     = randState();
`ifdef AES_MCOL_INV_EN
      inv   = 1'($urandom);
`else
      inv   = 1'b0;
`endif
      e = refMix(s, inv);
      runOne(which, s, inv, got, id, iv, lat, ok);
      testsRun++;
      if (!ok || lat != 5) begin testsFailed++; $display("[TB] FAIL rand%0d_latency got=%0d exp=5", t, lat); end
      testsRun++;
      if (got !== e) begin testsFailed++; $display("[TB] FAIL rand%0d_state got=%h exp=%h", t, got, e); end
      testsRun++;
      if (id !== which) begin testsFailed++; $display("[TB] FAIL rand%0d_id got=%b exp=%b", t, id, which); end
`ifdef AES_MCOL_INV_EN
      testsRun++;
      if (iv !== inv) begin testsFailed++; $display("[TB] FAIL rand%0d_inv got=%b exp=%b", t, iv, inv); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_forward();
    test_tie_round_robin();
    test_backpressure();
    test_reset_mid_run();
`ifdef AES_MCOL_INV_EN
    test_inverse();
`endif
    test_idle_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
